// File: rtl/oam_scanner_pkg.sv
// Shared types and constants for the PPU mode-2 object search.
package oam_scanner_pkg;

  typedef enum logic [2:0] {
    s_OAM_IDLE   = 3'd0,
    s_OAM_PRIME  = 3'd1,
    s_OAM_READ_Y = 3'd2,
    s_OAM_READ_X = 3'd3,
    s_OAM_DONE   = 3'd4
  } oam_scan_state_t;

  localparam int OAM_NUM_OBJ  = 40;
  localparam int OAM_MAX_HIT  = 10;
  localparam int OAM_Y_OFFSET = 16;

  // Sized forms so that comparisons against narrow counters stay width-matched
  localparam logic [5:0] OAM_LAST_IDX = 6'(OAM_NUM_OBJ - 1);
  localparam logic [3:0] OAM_MAX_CNT  = 4'(OAM_MAX_HIT);
  localparam logic [8:0] OAM_Y_BIAS   = 9'(OAM_Y_OFFSET);

  typedef struct packed {
    logic [5:0] idx;
    logic [7:0] x;
    logic [3:0] row;
  } obj_hit_t;

  // Object height in rows for the LCDC object-size bit
  function automatic logic [8:0] obj_height(input logic tall);
    return tall ? 9'd16 : 9'd8;
  endfunction

endpackage

// File: rtl/oam_scanner_line_buffer.sv
// Per-line store of the objects found by the scan, written in OAM order.
module oam_scanner_line_buffer
  import oam_scanner_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       we,
  input  logic [3:0] waddr,
  input  obj_hit_t   wdata,
  input  logic [3:0] raddr,
  output obj_hit_t   rdata
);

  obj_hit_t slot_q [OAM_MAX_HIT];
  obj_hit_t slot_d [OAM_MAX_HIT];

  // Next contents: clear wins over a write; out-of-range writes are dropped
  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      for (int i = 0; i < OAM_MAX_HIT; i++) begin
        slot_d[i] = '0;
      end
    end else if (we && (waddr < OAM_MAX_CNT)) begin
      slot_d[waddr] = wdata;
    end else begin
      slot_d = slot_q;
    end
  end

  // Slot storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OAM_MAX_HIT; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      slot_q <= slot_d;
    end
  end

  // Combinational read port; indices past the depth read as zero
  always_comb begin
    rdata = '0;
    if (raddr < OAM_MAX_CNT) begin
      rdata = slot_q[raddr];
    end else begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/oam_scanner.sv
// Mode-2 OAM search: reads Y/X of all 40 entries and keeps the first 10 on the line.
module oam_scanner
  import oam_scanner_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] ly,
  input  logic       obj_size,
  output logic [7:0] disp_address_oam,
  output logic       ld_disp_address_oam,
  output logic       oe_oam,
  input  logic [7:0] disp_data_oam,
  output logic       busy,
  output logic       done,
  output logic [3:0] sprite_count,
  input  logic [3:0] rd_idx,
  output logic [5:0] rd_oam_index,
  output logic [7:0] rd_x,
  output logic [3:0] rd_row
);

  oam_scan_state_t state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [3:0] count_q, count_d;
  logic [7:0] ly_q, ly_d;
  logic       size_q, size_d;
  logic       hit_q, hit_d;
  logic [3:0] row_q, row_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [8:0] diff_s;
  logic       we_s;
  logic       clr_s;
  logic [7:0] addr_s;
  logic       ld_s;
  logic       oe_s;
  obj_hit_t   wdata_s;
  obj_hit_t   buf_rdata_s;
  obj_hit_t   rd_entry_s;

  // Scan sequencing, hit test and address/load decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    ly_d    = ly_q;
    size_d  = size_q;
    hit_d   = hit_q;
    row_d   = row_q;
    we_s    = 1'b0;
    clr_s   = 1'b0;
    addr_s  = 8'd0;
    ld_s    = 1'b0;
    oe_s    = 1'b0;
    // Objects above the line wrap to >= 240 in 9 bits and so always miss
    diff_s  = {1'b0, ly_q} + OAM_Y_BIAS - {1'b0, disp_data_oam};
    wdata_s = '{idx: idx_q, x: disp_data_oam, row: row_q};
    case (state_q)
      s_OAM_IDLE: begin
        if (start) begin
          ly_d    = ly;
          size_d  = obj_size;
          idx_d   = 6'd0;
          count_d = 4'd0;
          clr_s   = 1'b1;
          state_d = s_OAM_PRIME;
        end else begin
          state_d = s_OAM_IDLE;
        end
      end
      s_OAM_PRIME: begin
        addr_s  = {idx_q, 2'b00};
        ld_s    = 1'b1;
        oe_s    = 1'b1;
        state_d = s_OAM_READ_Y;
      end
      s_OAM_READ_Y: begin
        addr_s  = {idx_q, 2'b01};
        ld_s    = 1'b1;
        oe_s    = 1'b1;
        hit_d   = (diff_s < obj_height(size_q));
        row_d   = diff_s[3:0];
        state_d = s_OAM_READ_X;
      end
      s_OAM_READ_X: begin
        oe_s = 1'b1;
        if (hit_q && (count_q < OAM_MAX_CNT)) begin
          we_s    = 1'b1;
          count_d = count_q + 4'd1;
        end else begin
          we_s    = 1'b0;
        end
        if (idx_q < OAM_LAST_IDX) begin
          addr_s  = {idx_q + 6'd1, 2'b00};
          ld_s    = 1'b1;
          idx_d   = idx_q + 6'd1;
          state_d = s_OAM_READ_Y;
        end else begin
          ld_s    = 1'b0;
          state_d = s_OAM_DONE;
        end
      end
      s_OAM_DONE: begin
        state_d = s_OAM_IDLE;
      end
      default: begin
        state_d = s_OAM_IDLE;
      end
    endcase
    busy_d = (state_d == s_OAM_PRIME) || (state_d == s_OAM_READ_Y) ||
             (state_d == s_OAM_READ_X);
    done_d = (state_d == s_OAM_DONE);
  end

  // FSM state, scan context and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= s_OAM_IDLE;
      idx_q   <= 6'd0;
      count_q <= 4'd0;
      ly_q    <= 8'd0;
      size_q  <= 1'b0;
      hit_q   <= 1'b0;
      row_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      ly_q    <= ly_d;
      size_q  <= size_d;
      hit_q   <= hit_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  oam_scanner_line_buffer u_line_buffer (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .we    (we_s),
    .waddr (count_q),
    .wdata (wdata_s),
    .raddr (rd_idx),
    .rdata (buf_rdata_s)
  );

  // Slots at or past the stored count read back as zero
  always_comb begin
    rd_entry_s = '0;
    if (rd_idx < count_q) begin
      rd_entry_s = buf_rdata_s;
    end else begin
      rd_entry_s = '0;
    end
  end

  assign disp_address_oam    = addr_s;
  assign ld_disp_address_oam = ld_s;
  assign oe_oam              = oe_s;
  assign busy                = busy_q;
  assign done                = done_q;
  assign sprite_count        = count_q;
  assign rd_oam_index        = rd_entry_s.idx;
  assign rd_x                = rd_entry_s.x;
  assign rd_row              = rd_entry_s.row;

endmodule

// File: tb/tb_oam_scanner.sv
// Self-checking bench for oam_scanner with a behavioural OAM and a scoreboard.
module tb_oam_scanner;

  typedef struct packed {
    logic [5:0] idx;
    logic [7:0] x;
    logic [3:0] row;
  } hit_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] ly = 8'd0;
  logic       obj_size = 1'b0;
  logic [7:0] disp_address_oam;
  logic       ld_disp_address_oam;
  logic       oe_oam;
  logic [7:0] disp_data_oam = 8'd0;
  logic       busy;
  logic       done;
  logic [3:0] sprite_count;
  logic [3:0] rd_idx = 4'd0;
  logic [5:0] rd_oam_index;
  logic [7:0] rd_x;
  logic [3:0] rd_row;

  logic [7:0] oam [0:159];
  hit_t       exp_q[$];
  logic [7:0] addr_q[$];
  int         errors = 0;
  int         checks = 0;

  oam_scanner dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .ly                  (ly),
    .obj_size            (obj_size),
    .disp_address_oam    (disp_address_oam),
    .ld_disp_address_oam (ld_disp_address_oam),
    .oe_oam              (oe_oam),
    .disp_data_oam       (disp_data_oam),
    .busy                (busy),
    .done                (done),
    .sprite_count        (sprite_count),
    .rd_idx              (rd_idx),
    .rd_oam_index        (rd_oam_index),
    .rd_x                (rd_x),
    .rd_row              (rd_row)
  );

  always #5 clk = ~clk;

  // OAM byte appears the cycle after the address is loaded
  always @(posedge clk) begin
    if (ld_disp_address_oam && oe_oam && (disp_address_oam < 8'd160)) begin
      disp_data_oam <= oam[disp_address_oam];
    end
  end

  task automatic clear_oam();
    for (int i = 0; i < 160; i++) oam[i] = 8'd0;
  endtask

  // Runs one full scan and checks trace, latency, count and buffer contents
  task automatic run_scan(input logic [7:0] l, input logic sz, input string name);
    int s;
    int busy_n;
    bit seen;
    logic [8:0] d;
    logic [7:0] a;
    hit_t h;
    int n;
    exp_q.delete();
    addr_q.delete();
    for (int e = 0; e < 40; e++) begin
      d = {1'b0, l} + 9'd16 - {1'b0, oam[4*e]};
      if ((d < (sz ? 9'd16 : 9'd8)) && (exp_q.size() < 10)) begin
        h.idx = 6'(e);
        h.x   = oam[4*e+1];
        h.row = d[3:0];
        exp_q.push_back(h);
      end
    end
    addr_q.push_back(8'h00);
    for (int e = 0; e < 40; e++) begin
      a = 8'(4*e + 1);
      addr_q.push_back(a);
      if (e < 39) begin
        a = 8'(4*e + 4);
        addr_q.push_back(a);
      end
    end
    start = 1'b1; ly = l; obj_size = sz;
    @(posedge clk); #1;
    start = 1'b0; ly = ~l; obj_size = ~sz;
    s = 0; busy_n = 0; seen = 1'b0;
    while (!seen && s < 200) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_n++;
        if (ld_disp_address_oam) begin
          checks++;
          if (addr_q.size() == 0) begin
            errors++;
            $display("FAIL %s extra_ld: got addr %h, expected no load", name, disp_address_oam);
          end else begin
            a = addr_q.pop_front();
            if ({oe_oam, disp_address_oam} !== {1'b1, a}) begin
              errors++;
              $display("FAIL %s addr_trace: got oe=%b addr=%h, expected oe=1 addr=%h",
                       name, oe_oam, disp_address_oam, a);
            end
          end
        end
        @(posedge clk); #1;
        s++;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: done not seen within %0d cycles", name, s);
    end
    checks++;
    if (s !== 81) begin
      errors++;
      $display("FAIL %s latency: got done after %0d edges, expected 81", name, s);
    end
    checks++;
    if (busy_n !== 81) begin
      errors++;
      $display("FAIL %s busy_len: got %0d cycles, expected 81", name, busy_n);
    end
    checks++;
    if (addr_q.size() !== 0) begin
      errors++;
      $display("FAIL %s trace_len: got %0d missing loads, expected 0", name, addr_q.size());
    end
    checks++;
    if ({busy, ld_disp_address_oam, oe_oam} !== 3'b000) begin
      errors++;
      $display("FAIL %s done_outputs: got busy/ld/oe=%b, expected 000",
               name, {busy, ld_disp_address_oam, oe_oam});
    end
    checks++;
    if (sprite_count !== 4'(exp_q.size())) begin
      errors++;
      $display("FAIL %s sprite_count: got %0d, expected %0d", name, sprite_count, exp_q.size());
    end
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      h = exp_q.pop_front();
      rd_idx = 4'(k); #1;
      checks++;
      if ({rd_oam_index, rd_x, rd_row} !== {h.idx, h.x, h.row}) begin
        errors++;
        $display("FAIL %s slot%0d: got idx=%0d x=%0d row=%0d, expected idx=%0d x=%0d row=%0d",
                 name, k, rd_oam_index, rd_x, rd_row, h.idx, h.x, h.row);
      end
    end
    rd_idx = 4'(n); #1;
    checks++;
    if ({rd_oam_index, rd_x, rd_row} !== 18'd0) begin
      errors++;
      $display("FAIL %s empty_slot%0d: got idx=%0d x=%0d row=%0d, expected zeros",
               name, n, rd_oam_index, rd_x, rd_row);
    end
    rd_idx = 4'd15; #1;
    checks++;
    if ({rd_oam_index, rd_x, rd_row} !== 18'd0) begin
      errors++;
      $display("FAIL %s slot15: got idx=%0d x=%0d row=%0d, expected zeros",
               name, rd_oam_index, rd_x, rd_row);
    end
    rd_idx = 4'd0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got done=%b one cycle later, expected 0", name, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, ld_disp_address_oam, oe_oam, disp_address_oam, sprite_count,
         rd_oam_index, rd_x, rd_row} !== 34'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b ld=%b oe=%b addr=%h count=%0d, expected zeros",
               busy, done, ld_disp_address_oam, oe_oam, disp_address_oam, sprite_count);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_all_zero();
    clear_oam();
    run_scan(8'd0, 1'b0, "all_zero");
  endtask

  task automatic test_single();
    clear_oam();
    oam[12] = 8'd16;
    oam[13] = 8'd8;
    run_scan(8'd0, 1'b0, "single_ly0");
    run_scan(8'd7, 1'b0, "single_ly7");
    run_scan(8'd8, 1'b0, "single_ly8");
  endtask

  task automatic test_overflow();
    clear_oam();
    for (int i = 0; i < 12; i++) begin
      oam[4*i]   = 8'd20;
      oam[4*i+1] = 8'(i);
    end
    run_scan(8'd4, 1'b0, "overflow");
  endtask

  task automatic test_tall();
    clear_oam();
    oam[0] = 8'd16;
    oam[1] = 8'd33;
    run_scan(8'd15, 1'b1, "tall_row15");
    run_scan(8'd15, 1'b0, "short_miss");
    oam[0] = 8'd5;
    run_scan(8'd0, 1'b1, "tall_row11");
  endtask

  task automatic test_random();
    logic [7:0] l;
    logic sz;
    for (int it = 0; it < 3; it++) begin
      l  = 8'($urandom_range(0, 143));
      sz = 1'($urandom_range(0, 1));
      for (int e = 0; e < 40; e++) begin
        oam[4*e]   = 8'(int'(l) + $urandom_range(0, 26));
        oam[4*e+1] = 8'($urandom_range(0, 255));
      end
      run_scan(l, sz, "random");
    end
  endtask

  task automatic test_reset_mid();
    clear_oam();
    for (int i = 0; i < 12; i++) begin
      oam[4*i]   = 8'd20;
      oam[4*i+1] = 8'(i + 100);
    end
    start = 1'b1; ly = 8'd4; obj_size = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({busy, ld_disp_address_oam, disp_address_oam} !== {1'b1, 1'b1, 8'h3D}) begin
      errors++;
      $display("FAIL restart_ignored: got busy=%b ld=%b addr=%h, expected busy=1 ld=1 addr=3d",
               busy, ld_disp_address_oam, disp_address_oam);
    end
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; #2;
    checks++;
    if ({busy, done, ld_disp_address_oam, oe_oam, disp_address_oam, sprite_count,
         rd_oam_index, rd_x, rd_row} !== 34'd0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b done=%b ld=%b oe=%b addr=%h count=%0d x=%0d, expected zeros",
               busy, done, ld_disp_address_oam, oe_oam, disp_address_oam, sprite_count, rd_x);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 90; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL post_reset_idle: got busy=%b done=%b at cycle %0d, expected 00", busy, done, c);
      end
    end
    run_scan(8'd4, 1'b0, "after_reset");
  endtask

  initial begin
    clear_oam();
    test_reset();
    test_all_zero();
    test_single();
    test_overflow();
    test_tall();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
